instr_seq: RTL and testbench
============================

# instr_seq

Instruction decode and sequencing controller for picoMIPS; sits directly downstream of the program counter/program memory and upstream of the register file, ALU and multiplier. Each cycle it decodes the instruction addressed by the current PC, drives datapath controls, and returns PCincr/Branchaddr to the PC. Multi-cycle operations (MULI, WAITIN) stall the PC by reloading its own value as the branch address.

## Interface
- Psize, 5, PC/branch-address width
- Isize, 18, instruction width; fields: op[17:15], rd[14:12], rs[11:9], imm[7:0]; bit 8 unused
- clk  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- pc_in  in  Psize  current PC value (PCout of the PC)
- instr  in  Isize  instruction at pc_in, combinational program-memory read
- zflag  in  1  ALU zero result for the current instruction (rd − rs)
- mul_done  in  1  multiplier result valid, single-cycle pulse
- in_valid  in  1  external input data valid (level)
- PCincr  out  1  1 = increment PC; 0 = load Branchaddr
- Branchaddr  out  Psize  PC load value
- rd_addr, rs_addr  out  3  register-file addresses (instr fields)
- imm  out  8  immediate field
- alu_op  out  2  ADD=0, SUB=1, PASS_B=2
- imm_sel  out  1  ALU B operand: 1 = imm, 0 = rs data
- wsrc  out  2  write-back source: ALU=0, MUL=1, IN=2
- reg_we  out  1  register-file write enable
- mul_start  out  1  one-cycle multiplier start pulse
- in_ack  out  1  one-cycle input acknowledge
- halted  out  1  HALT reached
- retired  out  16  retired-instruction count

## Operation
- Opcodes: NOP 000, ADD 001, ADDI 010, SUB 011, MULI 100, BEQ 101, WAITIN 110, HALT 111.
- "Hold" = PCincr=0, Branchaddr=pc_in.
- Registered `run` flag: cleared by reset, set on first clk edge after release. While run=0: hold, reg_we=mul_start=in_ack=0.
- FSM states EXEC, MULWAIT, INWAIT, HALT; reset → EXEC.
- EXEC: NOP → PCincr=1. ADD/SUB → reg_we=1, wsrc=ALU, imm_sel=0, PCincr=1. ADDI → as ADD with imm_sel=1. BEQ → if zflag: PCincr=0, Branchaddr=imm[Psize-1:0]; else PCincr=1; reg_we=0. MULI → mul_start=1, hold, → MULWAIT. WAITIN → hold, → INWAIT. HALT → hold, → HALT.
- MULWAIT: hold until mul_done; then reg_we=1, wsrc=MUL, PCincr=1, → EXEC. mul_start stays 0.
- INWAIT: hold until in_valid=1 and `armed`=1; then reg_we=1, wsrc=IN, in_ack=1, PCincr=1, → EXEC. `armed` cleared on in_ack, set when in_valid seen 0; reset value 1. A source holding in_valid high across two WAITINs is consumed once.
- HALT: hold indefinitely, halted=1; exit only via reset.
- retired increments by 1 on every cycle with PCincr=1 or a taken branch while not holding; wraps at 2^16.
- Field outputs (rd_addr, rs_addr, imm) are always driven from instr, in every state.

## Timing
- Decode is combinational from instr/state; PC updates at the next posedge. Single-cycle ops retire one per clock.
- MULI: ≥2 cycles (start + ≥1 wait); mul_done in the start cycle is ignored.
- WAITIN: minimum 2 cycles.
- Branch to self allowed (BEQ imm = pc_in loops while zflag).
- PC wrap at 2^Psize−1 is handled by the PC; no special case here.
- Reset mid-MULWAIT/INWAIT: state → EXEC, run=0, armed=1, retired=0, all pulses low immediately (async). The multiplier shares the same reset.
- Reset values: PCincr=0, Branchaddr=pc_in, reg_we=0, mul_start=0, in_ack=0, halted=0, retired=0.

## Structure
- Package picomips_pkg: opcode enum, alu_op enum, wsrc enum, field bit-position localparams, fsm state enum.
- One combinational sub-module op_decode (instr → op class, alu_op, imm_sel, wsrc). FSM, run/armed flags and the counter live in instr_seq.

## Test plan
- Reset release with PC=0, instr=ADDI r1,5 → first cycle held (PCincr=0, Branchaddr=0, reg_we=0); next cycle reg_we=1, imm_sel=1, PCincr=1, retired=1.
- BEQ imm=0x13 with zflag=1 → PCincr=0, Branchaddr=0x13; with zflag=0 → PCincr=1, no write.
- MULI, mul_done after 3 cycles → mul_start pulses once; PC held 3 cycles; write cycle reg_we=1, wsrc=1, PCincr=1.
- WAITIN twice with in_valid held high → first accepted (in_ack=1, wsrc=2); second waits until in_valid drops and rises again.
- HALT → halted=1, PC held 20 cycles, retired frozen; reset clears halted.
- Reset asserted during MULWAIT → state EXEC, mul_start/reg_we stay 0, retired=0, one bubble cycle after release.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared types and field positions for the picoMIPS decode/sequencing logic.
package picomips_pkg;

    localparam int unsigned PSIZE   = 5;
    localparam int unsigned ISIZE   = 18;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned RET_W   = 16;

    localparam int unsigned OP_LSB  = 15;
    localparam int unsigned RD_LSB  = 12;
    localparam int unsigned RS_LSB  = 9;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 3'b000,
        OP_ADD    = 3'b001,
        OP_ADDI   = 3'b010,
        OP_SUB    = 3'b011,
        OP_MULI   = 3'b100,
        OP_BEQ    = 3'b101,
        OP_WAITIN = 3'b110,
        OP_HALT   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_PASS_B = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WSRC_ALU = 2'd0,
        WSRC_MUL = 2'd1,
        WSRC_IN  = 2'd2
    } wsrc_e;

    typedef enum logic [1:0] {
        ST_EXEC    = 2'd0,
        ST_MULWAIT = 2'd1,
        ST_INWAIT  = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    typedef struct packed {
        opcode_e op;
        alu_op_e alu_op;
        logic    imm_sel;
        wsrc_e   wsrc;
    } decode_t;

    function automatic logic [OP_W-1:0] op_field(input logic [ISIZE-1:0] i);
        return i[OP_LSB +: OP_W];
    endfunction

endpackage

// File: rtl/instr_seq_op_decode.sv
// Pure opcode decode: op class plus the static datapath controls it implies.
module op_decode
    import picomips_pkg::*;
(
    input  logic [OP_W-1:0] op_bits,
    output decode_t         dec
);

    always_comb begin
        dec.op      = opcode_e'(op_bits);
        dec.alu_op  = ALU_PASS_B;
        dec.imm_sel = 1'b0;
        dec.wsrc    = WSRC_ALU;
        case (opcode_e'(op_bits))
            OP_ADD:    dec.alu_op = ALU_ADD;
            OP_ADDI: begin
                dec.alu_op  = ALU_ADD;
                dec.imm_sel = 1'b1;
            end
            OP_SUB:    dec.alu_op = ALU_SUB;
            // BEQ compares by subtraction; the ALU zero flag comes back as zflag
            OP_BEQ:    dec.alu_op = ALU_SUB;
            OP_MULI: begin
                dec.imm_sel = 1'b1;
                dec.wsrc    = WSRC_MUL;
            end
            OP_WAITIN: dec.wsrc = WSRC_IN;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_seq.sv
// picoMIPS instruction sequencer: decodes the instruction at the current PC,
// drives datapath controls and stalls the PC for multi-cycle operations.
module instr_seq
    import picomips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PSIZE-1:0]   pc_in,
    input  logic [ISIZE-1:0]   instr,
    input  logic               zflag,
    input  logic               mul_done,
    input  logic               in_valid,
    output logic               PCincr,
    output logic [PSIZE-1:0]   Branchaddr,
    output logic [REG_W-1:0]   rd_addr,
    output logic [REG_W-1:0]   rs_addr,
    output logic [IMM_W-1:0]   imm,
    output logic [1:0]         alu_op,
    output logic               imm_sel,
    output logic [1:0]         wsrc,
    output logic               reg_we,
    output logic               mul_start,
    output logic               in_ack,
    output logic               halted,
    output logic [RET_W-1:0]   retired
);

    state_e           state_q, state_d;
    logic             run_q;
    logic             armed_q;
    logic [RET_W-1:0] retired_q;
    logic             taken_c;
    logic             retire_c;
    wsrc_e            wsrc_c;
    decode_t          dec;
    logic             unused_bit8;

    op_decode u_dec (
        .op_bits (op_field(instr)),
        .dec     (dec)
    );

    assign unused_bit8 = instr[8];
    assign rd_addr     = instr[RD_LSB +: REG_W];
    assign rs_addr     = instr[RS_LSB +: REG_W];
    assign imm         = instr[IMM_LSB +: IMM_W];
    assign alu_op      = dec.alu_op;
    assign imm_sel     = dec.imm_sel;
    assign wsrc        = wsrc_c;
    assign halted      = (state_q == ST_HALT);
    assign retired     = retired_q;

    // State register plus run/armed flags and the retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_EXEC;
            run_q     <= 1'b0;
            armed_q   <= 1'b1;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (in_ack)
                armed_q <= 1'b0;
            else if (!in_valid)
                armed_q <= 1'b1;
            if (retire_c)
                retired_q <= retired_q + RET_W'(1);
        end
    end

    // Next state and sequencing controls; default is "hold"
    always_comb begin
        state_d    = state_q;
        PCincr     = 1'b0;
        Branchaddr = pc_in;
        reg_we     = 1'b0;
        mul_start  = 1'b0;
        in_ack     = 1'b0;
        taken_c    = 1'b0;
        wsrc_c     = dec.wsrc;
        if (run_q) begin
            case (state_q)
                ST_EXEC: begin
                    case (dec.op)
                        OP_NOP: PCincr = 1'b1;
                        OP_ADD, OP_ADDI, OP_SUB: begin
                            reg_we = 1'b1;
                            wsrc_c = WSRC_ALU;
                            PCincr = 1'b1;
                        end
                        OP_BEQ: begin
                            if (zflag) begin
                                taken_c    = 1'b1;
                                Branchaddr = instr[IMM_LSB +: PSIZE];
                            end else begin
                                PCincr = 1'b1;
                            end
                        end
                        OP_MULI: begin
                            mul_start = 1'b1;
                            state_d   = ST_MULWAIT;
                        end
                        OP_WAITIN: state_d = ST_INWAIT;
                        OP_HALT:   state_d = ST_HALT;
                        default: ;
                    endcase
                end
                ST_MULWAIT: begin
                    if (mul_done) begin
                        reg_we  = 1'b1;
                        wsrc_c  = WSRC_MUL;
                        PCincr  = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
                ST_INWAIT: begin
                    // armed blocks a level-held in_valid from feeding two WAITINs
                    if (in_valid && armed_q) begin
                        reg_we  = 1'b1;
                        wsrc_c  = WSRC_IN;
                        in_ack  = 1'b1;
                        PCincr  = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
                ST_HALT: ;
                default: state_d = ST_EXEC;
            endcase
        end
    end

    assign retire_c = PCincr | taken_c;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq with a behavioural PC and program memory.
module tb_instr_seq;

    logic        clk;
    logic        reset;
    logic [4:0]  pc;
    logic [17:0] instr;
    logic        zflag;
    logic        mul_done;
    logic        in_valid;
    logic        PCincr;
    logic [4:0]  Branchaddr;
    logic [2:0]  rd_addr, rs_addr;
    logic [7:0]  imm;
    logic [1:0]  alu_op;
    logic        imm_sel;
    logic [1:0]  wsrc;
    logic        reg_we, mul_start, in_ack, halted;
    logic [15:0] retired;

    logic [17:0] mem [32];
    int errors = 0;
    int checks = 0;

    instr_seq dut (
        .clk(clk), .reset(reset), .pc_in(pc), .instr(instr), .zflag(zflag),
        .mul_done(mul_done), .in_valid(in_valid), .PCincr(PCincr),
        .Branchaddr(Branchaddr), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
        .alu_op(alu_op), .imm_sel(imm_sel), .wsrc(wsrc), .reg_we(reg_we),
        .mul_start(mul_start), .in_ack(in_ack), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= 5'd0;
        else        pc <= PCincr ? pc + 5'd1 : Branchaddr;
    end
    assign instr = mem[pc];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [17:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] im);
        return {op, rd, rs, 1'b0, im};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = mk(3'b000, 3'd0, 3'd0, 8'd0);
    endtask

    // Reset, release, then step past the bubble cycle; returns at a negedge
    // where the first real instruction at PC 0 is being decoded.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; zflag = 1'b0; mul_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = mk(3'b010, 3'd1, 3'd0, 8'd5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (PCincr !== 1'b0 || reg_we !== 1'b0 || mul_start !== 1'b0 || in_ack !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: PCincr=%b reg_we=%b mul_start=%b in_ack=%b want 0", PCincr, reg_we, mul_start, in_ack);
        end
        checks++; if (halted !== 1'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL reset_state: halted=%b retired=%0d want 0/0", halted, retired);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (PCincr !== 1'b0 || Branchaddr !== 5'd0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL bubble: PCincr=%b Branchaddr=%0d reg_we=%b want 0/0/0", PCincr, Branchaddr, reg_we);
        end
        @(negedge clk); #1;
        checks++; if (pc !== 5'd0 || reg_we !== 1'b1 || imm_sel !== 1'b1 || PCincr !== 1'b1 || wsrc !== 2'd0) begin
            errors++; $display("FAIL addi_exec: pc=%0d reg_we=%b imm_sel=%b PCincr=%b wsrc=%0d want 0/1/1/1/0", pc, reg_we, imm_sel, PCincr, wsrc);
        end
        checks++; if (rd_addr !== 3'd1 || imm !== 8'd5 || alu_op !== 2'd0) begin
            errors++; $display("FAIL addi_fields: rd=%0d imm=%0d alu_op=%0d want 1/5/0", rd_addr, imm, alu_op);
        end
        @(negedge clk); #1;
        checks++; if (retired !== 16'd1 || pc !== 5'd1) begin
            errors++; $display("FAIL addi_retire: retired=%0d pc=%0d want 1/1", retired, pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_alu [3];
        logic       exp_sel [3];
        clear_mem();
        mem[0] = mk(3'b001, 3'd1, 3'd2, 8'd0);
        mem[1] = mk(3'b011, 3'd3, 3'd4, 8'd0);
        mem[2] = mk(3'b010, 3'd5, 3'd0, 8'd9);
        exp_alu[0] = 2'd0; exp_alu[1] = 2'd1; exp_alu[2] = 2'd0;
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b0; exp_sel[2] = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (pc !== 5'(i) || PCincr !== 1'b1 || reg_we !== 1'b1 || alu_op !== exp_alu[i] || imm_sel !== exp_sel[i]) begin
                errors++; $display("FAIL b2b_%0d: pc=%0d PCincr=%b reg_we=%b alu_op=%0d imm_sel=%b want %0d/1/1/%0d/%b",
                                   i, pc, PCincr, reg_we, alu_op, imm_sel, i, exp_alu[i], exp_sel[i]);
            end
            @(negedge clk); #1;
        end
        checks++; if (retired !== 16'd3 || pc !== 5'd3) begin
            errors++; $display("FAIL b2b_retired: retired=%0d pc=%0d want 3/3", retired, pc);
        end
    endtask

    task automatic test_beq();
        clear_mem();
        mem[0]     = mk(3'b101, 3'd1, 3'd2, 8'h13);
        mem[5'h13] = mk(3'b101, 3'd1, 3'd2, 8'h05);
        do_reset();
        zflag = 1'b1; #1;
        checks++; if (PCincr !== 1'b0 || Branchaddr !== 5'h13 || reg_we !== 1'b0 || alu_op !== 2'd1) begin
            errors++; $display("FAIL beq_taken: PCincr=%b Branchaddr=%h reg_we=%b alu_op=%0d want 0/13/0/1", PCincr, Branchaddr, reg_we, alu_op);
        end
        @(negedge clk);
        zflag = 1'b0; #1;
        checks++; if (pc !== 5'h13 || retired !== 16'd1) begin
            errors++; $display("FAIL beq_target: pc=%h retired=%0d want 13/1", pc, retired);
        end
        checks++; if (PCincr !== 1'b1 || reg_we !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken: PCincr=%b reg_we=%b want 1/0", PCincr, reg_we);
        end
        @(negedge clk); #1;
        checks++; if (pc !== 5'h14 || retired !== 16'd2) begin
            errors++; $display("FAIL beq_fallthru: pc=%h retired=%0d want 14/2", pc, retired);
        end
    endtask

    task automatic test_muli();
        int starts = 0;
        clear_mem();
        mem[0] = mk(3'b100, 3'd2, 3'd1, 8'd3);
        do_reset();
        mul_done = 1'b1; #1;
        starts += int'(mul_start);
        checks++; if (mul_start !== 1'b1 || PCincr !== 1'b0 || Branchaddr !== 5'd0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL muli_start: mul_start=%b PCincr=%b Branchaddr=%0d reg_we=%b want 1/0/0/0", mul_start, PCincr, Branchaddr, reg_we);
        end
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            mul_done = 1'b0; #1;
            starts += int'(mul_start);
            checks++; if (pc !== 5'd0 || PCincr !== 1'b0 || reg_we !== 1'b0) begin
                errors++; $display("FAIL muli_wait_%0d: pc=%0d PCincr=%b reg_we=%b want 0/0/0", c, pc, PCincr, reg_we);
            end
        end
        @(negedge clk);
        mul_done = 1'b1; #1;
        starts += int'(mul_start);
        checks++; if (reg_we !== 1'b1 || wsrc !== 2'd1 || PCincr !== 1'b1) begin
            errors++; $display("FAIL muli_write: reg_we=%b wsrc=%0d PCincr=%b want 1/1/1", reg_we, wsrc, PCincr);
        end
        @(negedge clk);
        mul_done = 1'b0; #1;
        checks++; if (starts != 1) begin
            errors++; $display("FAIL muli_pulses: mul_start pulses=%0d want 1", starts);
        end
        checks++; if (pc !== 5'd1 || retired !== 16'd1) begin
            errors++; $display("FAIL muli_retire: pc=%0d retired=%0d want 1/1", pc, retired);
        end
    endtask

    task automatic test_waitin();
        clear_mem();
        mem[0] = mk(3'b110, 3'd3, 3'd0, 8'd0);
        mem[1] = mk(3'b110, 3'd4, 3'd0, 8'd0);
        in_valid = 1'b1;
        do_reset();
        checks++; if (PCincr !== 1'b0 || in_ack !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL waitin1_issue: PCincr=%b in_ack=%b reg_we=%b want 0/0/0", PCincr, in_ack, reg_we);
        end
        @(negedge clk); #1;
        checks++; if (in_ack !== 1'b1 || wsrc !== 2'd2 || reg_we !== 1'b1 || PCincr !== 1'b1 || rd_addr !== 3'd3) begin
            errors++; $display("FAIL waitin1_accept: in_ack=%b wsrc=%0d reg_we=%b PCincr=%b rd=%0d want 1/2/1/1/3", in_ack, wsrc, reg_we, PCincr, rd_addr);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (pc !== 5'd1 || in_ack !== 1'b0 || PCincr !== 1'b0) begin
                errors++; $display("FAIL waitin2_block_%0d: pc=%0d in_ack=%b PCincr=%b want 1/0/0", c, pc, in_ack, PCincr);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; #1;
        checks++; if (in_ack !== 1'b0 || PCincr !== 1'b0) begin
            errors++; $display("FAIL waitin2_low: in_ack=%b PCincr=%b want 0/0", in_ack, PCincr);
        end
        @(negedge clk);
        in_valid = 1'b1; #1;
        checks++; if (in_ack !== 1'b1 || wsrc !== 2'd2 || PCincr !== 1'b1 || rd_addr !== 3'd4) begin
            errors++; $display("FAIL waitin2_accept: in_ack=%b wsrc=%0d PCincr=%b rd=%0d want 1/2/1/4", in_ack, wsrc, PCincr, rd_addr);
        end
        @(negedge clk);
        in_valid = 1'b0; #1;
        checks++; if (pc !== 5'd2 || retired !== 16'd2) begin
            errors++; $display("FAIL waitin_retire: pc=%0d retired=%0d want 2/2", pc, retired);
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        clear_mem();
        mem[0] = mk(3'b001, 3'd1, 3'd2, 8'd0);
        mem[1] = mk(3'b111, 3'd0, 3'd0, 8'd0);
        do_reset();
        @(negedge clk); #1;
        checks++; if (PCincr !== 1'b0 || Branchaddr !== 5'd1 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_issue: PCincr=%b Branchaddr=%0d halted=%b want 0/1/0", PCincr, Branchaddr, halted);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (halted !== 1'b1 || PCincr !== 1'b0 || pc !== 5'd1 || retired !== 16'd1 || reg_we !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL halt_hold: %0d of 20 cycles not held (halted=%b pc=%0d retired=%0d) want 0", bad, halted, pc, retired);
        end
        reset = 1'b0; #1;
        checks++; if (halted !== 1'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL halt_reset: halted=%b retired=%0d want 0/0", halted, retired);
        end
    endtask

    task automatic test_reset_mulwait();
        clear_mem();
        mem[1] = mk(3'b100, 3'd2, 3'd1, 8'd7);
        do_reset();
        @(negedge clk); #1;
        checks++; if (mul_start !== 1'b1 || retired !== 16'd1) begin
            errors++; $display("FAIL rmw_start: mul_start=%b retired=%0d want 1/1", mul_start, retired);
        end
        @(negedge clk);
        reset = 1'b0; mul_done = 1'b1; #1;
        checks++; if (mul_start !== 1'b0 || reg_we !== 1'b0 || PCincr !== 1'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL rmw_async: mul_start=%b reg_we=%b PCincr=%b retired=%0d want 0/0/0/0", mul_start, reg_we, PCincr, retired);
        end
        @(negedge clk);
        reset = 1'b1; mul_done = 1'b0; #1;
        checks++; if (PCincr !== 1'b0 || reg_we !== 1'b0 || pc !== 5'd0) begin
            errors++; $display("FAIL rmw_bubble: PCincr=%b reg_we=%b pc=%0d want 0/0/0", PCincr, reg_we, pc);
        end
        @(negedge clk); #1;
        checks++; if (PCincr !== 1'b1 || reg_we !== 1'b0 || pc !== 5'd0) begin
            errors++; $display("FAIL rmw_exec: PCincr=%b reg_we=%b pc=%0d want 1/0/0", PCincr, reg_we, pc);
        end
    endtask

    initial begin
        reset = 1'b0; zflag = 1'b0; mul_done = 1'b0; in_valid = 1'b0;
        clear_mem();
        test_reset();
        test_back_to_back();
        test_beq();
        test_muli();
        test_waitin();
        test_halt();
        test_reset_mulwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
